// File: rtl/i2s_encode_if.sv
// Sample-pair handshake between a producer and the I2S encoder.
// The producer drives the stereo pair and in_valid; the encoder returns in_ready.
interface i2s_encode_if #(
    parameter int RESOLUTION = 24
) ();
    logic [RESOLUTION-1:0] data_in_L;
    logic [RESOLUTION-1:0] data_in_R;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output data_in_L,
        output data_in_R,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  data_in_L,
        input  data_in_R,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/i2s_encode.sv
// I2S transmitter: one-deep holding register feeding an active sample pair,
// serialised LSB first with a one-SCLK delay after each LRCK transition.
module i2s_encode #(
    parameter int RESOLUTION = 24,
    parameter int SLOT_BITS  = 32,
    parameter int SCLK_DIV   = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    i2s_encode_if.slave  bus,
    output logic         SCLK,
    output logic         LRCK,
    output logic         SDATA,
    output logic         underrun
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int IDX_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] RES_C    = CNT_W'(RESOLUTION);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DIV_W-1:0]      div_q;
    logic [CNT_W-1:0]      bit_q;
    logic [RESOLUTION-1:0] hold_l;
    logic [RESOLUTION-1:0] hold_r;
    logic [RESOLUTION-1:0] act_l;
    logic [RESOLUTION-1:0] act_r;
    logic                  hold_full;

    logic                  running;
    logic                  tick;
    logic                  fall;
    logic                  wrap;
    logic                  to_idle;
    logic                  frame_start;
    logic                  ready;
    logic                  xfer;
    logic [CNT_W-1:0]      cnt_next;
    logic                  half;
    logic [CNT_W-1:0]      pos;
    logic [IDX_W-1:0]      bit_idx;
    logic [RESOLUTION-1:0] sel;
    logic                  sdata_d;

    assign ready        = ~hold_full & ~RST;
    assign bus.in_ready = ready;
    assign xfer         = bus.in_valid & ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A re-raised EN on the very wrap edge keeps streaming instead of idling.
    always_comb begin
        state_d     = state_q;
        running     = (state_q != IDLE);
        tick        = running && (div_q == DIV_LAST);
        fall        = tick && SCLK;
        wrap        = fall && (bit_q == LAST_C);
        cnt_next    = wrap ? '0 : bit_q + ONE_C;
        to_idle     = (state_q == DRAIN) && wrap && !EN;
        frame_start = wrap && !to_idle;

        case (state_q)
            IDLE:    if (EN) state_d = RUN;
            RUN:     if (!EN) state_d = DRAIN;
            DRAIN: begin
                if (EN) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        half    = (cnt_next >= SLOT_C);
        pos     = half ? (cnt_next - SLOT_C) : cnt_next;
        sel     = half ? act_r : act_l;
        bit_idx = IDX_W'(pos - ONE_C);
        sdata_d = 1'b0;
        if ((pos != '0) && (pos <= RES_C)) begin
            sdata_d = sel[bit_idx];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            bit_q     <= LAST_C;
            SCLK      <= 1'b0;
            LRCK      <= 1'b1;
            SDATA     <= 1'b0;
            underrun  <= 1'b0;
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            act_l     <= '0;
            act_r     <= '0;
        end else begin
            underrun <= 1'b0;

            if (!running) begin
                div_q <= '0;
            end else if (tick) begin
                div_q <= '0;
                SCLK  <= ~SCLK;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (fall) begin
                if (to_idle) begin
                    bit_q <= LAST_C;
                    LRCK  <= 1'b1;
                    SDATA <= 1'b0;
                end else begin
                    bit_q <= cnt_next;
                    LRCK  <= half;
                    SDATA <= sdata_d;
                end
            end

            // Holding is only loadable when empty, so a frame start that
            // drains it can never coincide with a new transfer.
            if (frame_start) begin
                if (hold_full) begin
                    act_l     <= hold_l;
                    act_r     <= hold_r;
                    hold_full <= 1'b0;
                end else begin
                    act_l    <= '0;
                    act_r    <= '0;
                    underrun <= 1'b1;
                end
            end

            if (xfer) begin
                hold_l    <= bus.data_in_L;
                hold_r    <= bus.data_in_R;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_encode.sv
// Directed bench for i2s_encode (RESOLUTION=24, SLOT_BITS=32, SCLK_DIV=2);
// a rising-SCLK receiver model rebuilds each half-frame word.
module tb_i2s_encode;

    logic clk;
    logic rst;
    logic en;
    logic sclk;
    logic lrck;
    logic sdata;
    logic underrun;

    i2s_encode_if #(.RESOLUTION(24)) bus ();

    i2s_encode #(
        .RESOLUTION(24),
        .SLOT_BITS(32),
        .SCLK_DIV(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .EN(en),
        .bus(bus.slave),
        .SCLK(sclk),
        .LRCK(lrck),
        .SDATA(sdata),
        .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos;
    int ucnt = 0;
    int hcnt = 0;
    int rise_cnt = 0;

    // Receiver: the rise that sees an LRCK change is the dummy slot, then bits 0..30.
    logic        prev_lr = 1'b1;
    int unsigned idx = 0;
    logic [31:0] word = '0;
    logic [31:0] dec_q[$];

    always @(posedge sclk) begin
        rise_cnt++;
        if (lrck != prev_lr) begin
            idx  = 0;
            word = '0;
        end else if (idx < 31) begin
            word[idx] = sdata;
            idx++;
            if (idx == 31) dec_q.push_back(word);
        end
        prev_lr = lrck;
    end

    always @(posedge clk) begin
        if (underrun) ucnt++;
        if (sdata) hcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // pos counts edges since EN was raised: pos=n means just after edge E0+n.
    task automatic advance_to(input int n);
        while (pos < n) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        en           = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    int s0;
    int u0;
    int h0;
    int r0;
    logic [31:0] pat;

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in_L = '0;
        bus.data_in_R = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_lrck", lrck, 1);
        check("rst_sdata", sdata, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.in_ready, 1);

        // Continuous valid pair: timing of first SCLK edges and frame length.
        bus.data_in_L = 24'h000001;
        bus.data_in_R = 24'h800000;
        bus.in_valid  = 1'b1;
        en            = 1'b1;
        pos           = -1;
        s0            = dec_q.size();
        u0            = ucnt;
        advance_to(1);   check("sclk_e1", sclk, 0);
        advance_to(2);   check("first_rise", sclk, 1);
        advance_to(3);   check("lrck_before_fall", lrck, 1);
        advance_to(4);   check("first_fall_sclk", sclk, 0);
                         check("first_fall_lrck", lrck, 0);
        advance_to(131); check("left_end", lrck, 0);
        advance_to(132); check("right_start", lrck, 1);
        advance_to(259); check("right_end", lrck, 1);
        advance_to(260); check("frame2_start", lrck, 0);
        advance_to(772);
        check("hold_words", dec_q.size() - s0, 6);
        for (int i = 0; i < 3; i++) begin
            check("hold_L", dec_q[s0 + 2 * i], 32'h000001);
            check("hold_R", dec_q[s0 + 2 * i + 1], 32'h800000);
        end
        check("hold_no_underrun", ucnt - u0, 0);

        // No data, then a single transfer on a frame-start cycle.
        do_reset();
        en  = 1'b1;
        pos = -1;
        s0  = dec_q.size();
        u0  = ucnt;
        h0  = hcnt;
        advance_to(259);
        bus.data_in_L = 24'hABCDEF;
        bus.data_in_R = 24'h123456;
        bus.in_valid  = 1'b1;
        advance_to(260);
        bus.in_valid = 1'b0;
        check("late_xfer_underrun", underrun, 1);
        check("late_xfer_ready", bus.in_ready, 0);
        advance_to(515); check("ready_held_low", bus.in_ready, 0);
        advance_to(516); check("ready_after_load", bus.in_ready, 1);
                         check("no_underrun_loaded", underrun, 0);
        check("underrun_count", ucnt - u0, 2);
        check("sdata_quiet", hcnt - h0, 0);
        advance_to(772);
        check("late_words", dec_q.size() - s0, 6);
        for (int i = 0; i < 4; i++) check("underrun_zero", dec_q[s0 + i], 0);
        check("late_L", dec_q[s0 + 4], 32'hABCDEF);
        check("late_R", dec_q[s0 + 5], 32'h123456);

        // All-ones left sample: bit placement, then EN dropped mid-left.
        do_reset();
        bus.data_in_L = 24'hFFFFFF;
        bus.data_in_R = 24'h000000;
        bus.in_valid  = 1'b1;
        en            = 1'b1;
        pos           = -1;
        advance_to(0);
        bus.in_valid = 1'b0;
        s0  = dec_q.size();
        u0  = ucnt;
        pat = '0;
        for (int p = 0; p < 32; p++) begin
            advance_to(4 + 4 * p);
            pat[p] = sdata;
        end
        check("bit_positions", pat, 32'h01FFFFFE);
        advance_to(298);
        en = 1'b0;
        advance_to(515); check("drain_sclk", sclk, 1);
                         check("drain_lrck", lrck, 1);
        advance_to(516); check("idle_sclk", sclk, 0);
                         check("idle_lrck", lrck, 1);
                         check("idle_sdata", sdata, 0);
        r0 = rise_cnt;
        advance_to(540); check("idle_no_rise", rise_cnt - r0, 0);
                         check("idle_sclk_held", sclk, 0);
        check("drain_words", dec_q.size() - s0, 4);
        check("ones_L", dec_q[s0], 32'h00FFFFFF);
        check("ones_R", dec_q[s0 + 1], 0);
        check("drain_L", dec_q[s0 + 2], 0);
        check("drain_R", dec_q[s0 + 3], 0);
        check("drain_underruns", ucnt - u0, 1);

        // Re-raise EN, then abort with RST during p=10 of the right half.
        bus.data_in_L = 24'h0F0F0F;
        bus.data_in_R = 24'h00C3A5;
        bus.in_valid  = 1'b1;
        en            = 1'b1;
        pos           = -1;
        s0            = dec_q.size();
        advance_to(0);
        bus.in_valid = 1'b0;
        advance_to(3);   check("rerun_lrck_pre", lrck, 1);
        advance_to(4);   check("rerun_left", lrck, 0);
        advance_to(173);
        rst = 1'b1;
        en  = 1'b0;
        advance_to(174);
        check("abort_sclk", sclk, 0);
        check("abort_lrck", lrck, 1);
        check("abort_sdata", sdata, 0);
        check("abort_underrun", underrun, 0);
        check("abort_ready", bus.in_ready, 0);
        check("abort_words", dec_q.size() - s0, 1);
        check("rerun_L", dec_q[s0], 32'h0F0F0F);
        rst = 1'b0;
        #1;
        check("abort_ready_after", bus.in_ready, 1);

        @(negedge clk);
        bus.data_in_L = 24'h5A5A5A;
        bus.data_in_R = 24'hA5A5A5;
        bus.in_valid  = 1'b1;
        en            = 1'b1;
        pos           = -1;
        s0            = dec_q.size();
        advance_to(516);
        check("restart_words", dec_q.size() - s0, 4);
        for (int i = 0; i < 2; i++) begin
            check("restart_L", dec_q[s0 + 2 * i], 32'h5A5A5A);
            check("restart_R", dec_q[s0 + 2 * i + 1], 32'hA5A5A5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
